// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int REG0_IDX   = 0;
    localparam int MAX_REGS   = 1024;

    // Counts set bits; callers zero-extend their busy vector to MAX_REGS.
    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            cnt += 32'(v[i]);
        end
        return cnt;
    endfunction

    // An address names a real register if it is in range and not a hardwired zero.
    function automatic logic reg_valid(input int unsigned addr, input int unsigned nreg,
                                       input int unsigned zero_reg);
        return (addr < nreg) && !((zero_reg != 0) && (addr == REG0_IDX));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: busy bits, issue/write-back priority,
// issue readiness and the registered busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREG     = 2 ** ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_iss_valid,
    input  logic [ADDR_W-1:0] i_iss_rd,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    output logic              o_iss_ready,
    output logic [NREG-1:0]   o_busy,
    output logic [NREG-1:0]   o_busy_nxt,
    output logic [ADDR_W:0]   o_busy_cnt
);

    logic [NREG-1:0] r_busy;
    logic [ADDR_W:0] r_busy_cnt;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_iss_ok;
    logic            w_rd_busy;
    logic            w_ready;

    always_comb begin
        w_iss_ok  = reg_valid(32'(i_iss_rd), NREG, ZERO_REG);
        w_rd_busy = 1'b0;
        w_set     = '0;
        w_clr     = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i_iss_rd == ADDR_W'(i)) w_rd_busy = r_busy[i];
        end
        w_ready = !(w_iss_ok && w_rd_busy);
        for (int i = 0; i < NREG; i++) begin
            if (i_iss_valid && w_ready && w_iss_ok && (i_iss_rd == ADDR_W'(i))) w_set[i] = 1'b1;
            if (i_wr_en && (i_wr_addr == ADDR_W'(i))) w_clr[i] = 1'b1;
        end
        // A new issue outranks a same-edge write-back: the register owes another write.
        w_busy_nxt = (r_busy & ~w_clr) | w_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= (ADDR_W+1)'(popcount(MAX_REGS'(w_busy_nxt)));
        end
    end

    assign o_iss_ready = w_ready;
    assign o_busy      = r_busy;
    assign o_busy_nxt  = w_busy_nxt;
    assign o_busy_cnt  = r_busy_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-edge write-back data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREG     = 2 ** ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [DATA_W-1:0] r_mem [NREG];
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic              r_rs_busy;
    logic              r_rt_busy;

    logic [NREG-1:0]   w_busy;
    logic [NREG-1:0]   w_busy_nxt;
    logic              w_wr_ok;
    logic              w_rs_ok;
    logic              w_rt_ok;
    logic [DATA_W-1:0] w_rs_mem;
    logic [DATA_W-1:0] w_rt_mem;
    logic              w_rs_old_busy;
    logic              w_rt_old_busy;
    logic              w_rs_new_busy;
    logic              w_rt_new_busy;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic              w_rs_bval;
    logic              w_rt_bval;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_iss_valid (iss_valid),
        .i_iss_rd    (iss_rd),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .o_iss_ready (iss_ready),
        .o_busy      (w_busy),
        .o_busy_nxt  (w_busy_nxt),
        .o_busy_cnt  (busy_cnt)
    );

    assign w_wr_ok = wr_en && reg_valid(32'(wr_addr), NREG, ZERO_REG);
    assign w_rs_ok = reg_valid(32'(rs_addr), NREG, ZERO_REG);
    assign w_rt_ok = reg_valid(32'(rt_addr), NREG, ZERO_REG);

    always_comb begin
        w_rs_mem      = '0;
        w_rt_mem      = '0;
        w_rs_old_busy = 1'b0;
        w_rt_old_busy = 1'b0;
        w_rs_new_busy = 1'b0;
        w_rt_new_busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (rs_addr == ADDR_W'(i)) begin
                w_rs_mem      = r_mem[i];
                w_rs_old_busy = w_busy[i];
                w_rs_new_busy = w_busy_nxt[i];
            end
            if (rt_addr == ADDR_W'(i)) begin
                w_rt_mem      = r_mem[i];
                w_rt_old_busy = w_busy[i];
                w_rt_new_busy = w_busy_nxt[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // On a forwarded hit the post-edge busy bit is 0 unless an issue re-set it.
    always_comb begin
        w_rs_val  = '0;
        w_rt_val  = '0;
        w_rs_bval = 1'b0;
        w_rt_bval = 1'b0;
        if (w_rs_ok) begin
            w_rs_val  = (w_wr_ok && (wr_addr == rs_addr)) ? wr_data : w_rs_mem;
            w_rs_bval = (w_wr_ok && (wr_addr == rs_addr)) ? w_rs_new_busy : w_rs_old_busy;
        end
        if (w_rt_ok) begin
            w_rt_val  = (w_wr_ok && (wr_addr == rt_addr)) ? wr_data : w_rt_mem;
            w_rt_bval = (w_wr_ok && (wr_addr == rt_addr)) ? w_rt_new_busy : w_rt_old_busy;
        end
    end
`else
    always_comb begin
        w_rs_val  = w_rs_ok ? w_rs_mem : '0;
        w_rt_val  = w_rt_ok ? w_rt_mem : '0;
        w_rs_bval = w_rs_ok && w_rs_old_busy;
        w_rt_bval = w_rt_ok && w_rt_old_busy;
    end
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                r_mem[i] <= '0;
            end else if (w_wr_ok && (wr_addr == ADDR_W'(i))) begin
                r_mem[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_rs_busy <= 1'b0;
            r_rt_busy <= 1'b0;
        end else if (rd_en) begin
            r_rs_data <= w_rs_val;
            r_rt_data <= w_rt_val;
            r_rs_busy <= w_rs_bval;
            r_rt_busy <= w_rt_bval;
        end
    end

    assign rs_data = r_rs_data;
    assign rt_data = r_rt_data;
    assign rs_busy = r_rs_busy;
    assign rt_busy = r_rt_busy;

    // Unused when bypass is off; folded in so every scoreboard output has a reader.
    logic w_unused;
    assign w_unused = ^{w_rs_new_busy, w_rt_new_busy};

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with write-to-read bypass and a per-register pending-write scoreboard. It replaces the fixed 16×32 register memory in the processor datapath. It serves two registered read ports (rs/rt) in decode and one write-back port. It also lets issue logic stall on register-level RAW/WAW hazards. All state changes on the rising edge of `clk`; the negedge write of the previous generation is gone.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits.
- `ADDR_W`, 4, register address width.
- `NREG`, 2**ADDR_W, number of registers; must be ≤ 2**ADDR_W.
- `ZERO_REG`, 1, when 1 register 0 reads as zero, ignores writes and is never busy.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset: synchronous, active-high.
- `rd_en`  in  1  capture new read data this edge.
- `rs_addr`, `rt_addr`  in  ADDR_W  read addresses.
- `rs_data`, `rt_data`  out  DATA_W  registered read data.
- `rs_busy`, `rt_busy`  out  1  registered: the source register had a write pending.
- `iss_valid`  in  1  issue of an instruction that will write `iss_rd`.
- `iss_rd`  in  ADDR_W  destination register being issued.
- `iss_ready`  out  1  combinational: `iss_rd` is not busy.
- `wr_en`  in  1  write-back strobe.
- `wr_addr`  in  ADDR_W  write-back address.
- `wr_data`  in  DATA_W  write-back data.
- `busy_cnt`  out  ADDR_W+1  registered count of busy registers.

## Operation
- Write: at the edge with `wr_en`=1, `mem[wr_addr]` ← `wr_data`. The write is ignored when `wr_addr`≥`NREG`, or when `wr_addr`=0 and `ZERO_REG`=1.
- Read: at the edge with `rd_en`=1, `rs_data` ← `mem[rs_addr]` and `rt_data` ← `mem[rt_addr]`. The same applies to the `*_busy` outputs.
  - When `rd_en`=0, the read outputs hold.
  - An out-of-range address, or address 0 with `ZERO_REG`=1, reads 0 and not-busy.
- Scoreboard: one busy bit per register.
  - `iss_valid && iss_ready` sets `busy[iss_rd]`.
  - `wr_en` clears `busy[wr_addr]`.
  - Issue to register 0 with `ZERO_REG`=1 is accepted and has no effect; `iss_ready`=1.
- `iss_valid` while `iss_ready`=0 is dropped; the issuer must hold it (WAW stall).
- Simultaneous set and clear of the same register at one edge: the set wins, because the register now has a new pending write.
- A write to a register that is not busy still updates data; the busy bit stays 0.
- `busy_cnt` = popcount of the busy bits after the edge's updates, range 0..NREG.

## Timing
- Read latency: 1 cycle. Addresses are presented in cycle N; data is valid after edge N.
- Write-back to read: see Configuration. Without bypass, a read issued one cycle after the write sees the new value.
- `iss_ready` is combinational from `iss_rd` and the current busy bits. It does not include a same-cycle write-back clear.
- On reset (any edge with `rst`=1), all of the following become 0:
  - every `mem` entry and every busy bit;
  - `rs_data`, `rt_data`, `rs_busy`, `rt_busy`, `busy_cnt`.
  - Reset overrides a concurrent write, read or issue. A pending scoreboard entry is discarded mid-operation.

## Configuration
- `REGFILE_BYPASS_EN` defined: when `wr_en` and `wr_addr`==`rs_addr` (respectively `rt_addr`) at the read edge, the read port captures `wr_data` and reports busy=0, unless the same edge also sets busy for that register by issue.
- Not defined: the read captures the old array contents and the old busy bit. A same-edge write is visible one cycle later.

## Structure
- Package `regfile_pkg` holds:
  - the default `DATA_W`/`ADDR_W`;
  - the reg-0 index constant;
  - the function `popcount` for `busy_cnt`.
- Sub-module `regfile_scoreboard` holds the busy vector, the set/clear priority, `iss_ready` and `busy_cnt`. The top holds the data array, the read ports and the bypass muxing.

## Test plan
- Reset, then read r3/r7 → `rs_data`=`rt_data`=0, busy=0, `busy_cnt`=0.
- Write r5=0xDEADBEEF, next cycle read `rs_addr`=5 → `rs_data`=0xDEADBEEF one cycle later.
- Same edge: write r4=0x1234 and read r4 → 0x1234 with `REGFILE_BYPASS_EN` defined, 0 without it.
- Issue r9 → `rt_busy`=1 on a read of r9 and `busy_cnt`=1. A second issue to r9 gives `iss_ready`=0 and is dropped. Write-back of r9 clears busy and `busy_cnt`=0.
- Issue r2 and write-back r2 at the same edge → `busy[2]` stays 1 and `busy_cnt`=1.
- `ZERO_REG`=1: write r0=0xFFFFFFFF, then read r0 → 0, with issue to r0 giving `iss_ready`=1 and `busy_cnt` unchanged. Assert `rst` while r1 is busy → r1 reads 0 and not-busy.
